// File: rtl/acc_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc_cpu_pkg
//  Purpose  : Shared encodings for the 8-bit accumulator CPU: opcodes,
//             control-FSM state codes, ACC input-source select and ALU ops.
//             The ACCSRC_* and ALU_* values are also consumed by the
//             datapath mux and ALU, so they must not be renumbered.
//  Revision : 1.0  initial release
// ============================================================================
package acc_cpu_pkg;

    // Opcodes, IR[7:4]. 4'h9..4'hE are undefined.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control FSM state encoding
    localparam int         ST_W     = 3;
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    // ACC input-source select
    localparam logic [1:0] ACCSRC_ALU = 2'b00;
    localparam logic [1:0] ACCSRC_MEM = 2'b01;
    localparam logic [1:0] ACCSRC_IMM = 2'b10;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

endpackage : acc_cpu_pkg
`default_nettype wire

// File: rtl/acc_cu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : acc_cu_decoder
//  Purpose  : Combinational opcode classifier for the accumulator control
//             unit. Tells the FSM which memory phase an instruction needs,
//             which ALU operation it uses and whether it is undefined.
//  Ports    : opcode    in   OP_W  IR opcode field
//             isMemRd   out  1     LDA/ADD/SUB/AND need an operand read
//             isMemWr   out  1     STA needs a write
//             isAlu     out  1     ADD/SUB/AND (ACC <= ALU result)
//             aluOp     out  2     ALU op; PASS for non-ALU opcodes
//             illegal   out  1     opcode is undefined
//  Revision : 1.0  initial release
// ============================================================================
module acc_cu_decoder
    import acc_cpu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    output logic            isMemRd,
    output logic            isMemWr,
    output logic            isAlu,
    output logic [1:0]      aluOp,
    output logic            illegal
);

    always_comb begin
        isMemRd = 1'b0;
        isMemWr = 1'b0;
        isAlu   = 1'b0;
        aluOp   = ALU_PASS;
        illegal = 1'b0;
        case (opcode)
            OP_W'(OP_LDA): isMemRd = 1'b1;
            OP_W'(OP_STA): isMemWr = 1'b1;
            OP_W'(OP_ADD): begin isMemRd = 1'b1; isAlu = 1'b1; aluOp = ALU_ADD; end
            OP_W'(OP_SUB): begin isMemRd = 1'b1; isAlu = 1'b1; aluOp = ALU_SUB; end
            OP_W'(OP_AND): begin isMemRd = 1'b1; isAlu = 1'b1; aluOp = ALU_AND; end
            OP_W'(OP_NOP),
            OP_W'(OP_JMP),
            OP_W'(OP_JZ),
            OP_W'(OP_LDI),
            OP_W'(OP_HLT): ;
            default:       illegal = 1'b1;
        endcase
    end

endmodule : acc_cu_decoder
`default_nettype wire

// File: rtl/acc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : acc_control_unit
//  Purpose  : Multi-cycle control FSM for the 8-bit accumulator datapath.
//             Fetches {opcode, operand} into an internal IR, then sequences
//             ACC loads, ALU op, PC strobes and memory read/write requests.
//             A wait counter bounds every memory request; a request that
//             stays unanswered for WAIT_LIMIT cycles parks the FSM in ERROR.
//  Ports    : clk        in   1       rising-edge clock
//             reset      in   1       asynchronous active-high reset
//             memReady   in   1       memory completes current request
//             memDataIn  in   8       instruction (FETCH) / operand data
//             accZero    in   1       ACC == 0
//             memRead    out  1       read request, held until memReady
//             memWrite   out  1       write request, held until memReady
//             addrSel    out  1       0 = PC address, 1 = operand address
//             operand    out  OPND_W  IR operand field
//             loadAcc    out  1       ACC load strobe
//             accSrc     out  2       ACC source select
//             aluOp      out  2       ALU operation
//             incPC      out  1       PC increment strobe
//             loadPC     out  1       PC load strobe
//             halted     out  1       HALT or ERROR
//             busErr     out  1       ERROR
//             illegalOp  out  1       pulse on undefined opcode
//  Revision : 1.0  initial release
// ============================================================================
module acc_control_unit
    import acc_cpu_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int OPND_W     = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memReady,
    input  logic [OP_W+OPND_W-1:0] memDataIn,
    input  logic                   accZero,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   addrSel,
    output logic [OPND_W-1:0]      operand,
    output logic                   loadAcc,
    output logic [1:0]             accSrc,
    output logic [1:0]             aluOp,
    output logic                   incPC,
    output logic                   loadPC,
    output logic                   halted,
    output logic                   busErr,
    output logic                   illegalOp
);

    localparam int IR_W  = OP_W + OPND_W;
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [ST_W-1:0]  r_state;
    logic [IR_W-1:0]  r_ir;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [OP_W-1:0]  w_opcode;
    logic             w_is_mem_rd;
    logic             w_is_mem_wr;
    logic             w_is_alu;
    logic [1:0]       w_alu_op;
    logic             w_illegal;
    logic             w_mem_phase;
    logic [CNT_W-1:0] w_wait_inc;
    logic             w_timeout;

    assign w_opcode = r_ir[IR_W-1:OPND_W];

    acc_cu_decoder #(
        .OP_W (OP_W)
    ) u_decoder (
        .opcode  (w_opcode),
        .isMemRd (w_is_mem_rd),
        .isMemWr (w_is_mem_wr),
        .isAlu   (w_is_alu),
        .aluOp   (w_alu_op),
        .illegal (w_illegal)
    );

    // The counter holds the number of not-ready cycles already spent on the
    // current request. The cycle whose increment would reach WAIT_LIMIT is the
    // last chance: ready on that cycle still completes, otherwise ERROR.
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
    assign w_wait_inc  = r_wait_cnt + CNT_W'(1);
    assign w_timeout   = w_mem_phase && !memReady &&
                         (w_wait_inc == CNT_W'(WAIT_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_ir       <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (memReady) begin
                        r_ir       <= memDataIn;
                        r_wait_cnt <= '0;
                        r_state    <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state    <= S_ERROR;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                S_DECODE: begin
                    // Every exit from DECODE enters a fresh request phase
                    // (or a terminal state), so the counter restarts here.
                    r_wait_cnt <= '0;
                    if (w_is_mem_rd)
                        r_state <= S_MEM_RD;
                    else if (w_is_mem_wr)
                        r_state <= S_MEM_WR;
                    else if (w_opcode == OP_W'(OP_HLT))
                        r_state <= S_HALT;
                    else
                        r_state <= S_FETCH;
                end
                S_MEM_RD,
                S_MEM_WR: begin
                    if (memReady) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_FETCH;
                    end else if (w_timeout) begin
                        r_state    <= S_ERROR;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_ERROR: r_state <= S_ERROR;
                // Unreachable encodings are treated as a fault.
                default: r_state <= S_ERROR;
            endcase
        end
    end

    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_addr_sel;
    logic             w_load_acc;
    logic [1:0]       w_acc_src;
    logic             w_inc_pc;
    logic             w_load_pc;
    logic             w_halted;
    logic             w_bus_err;
    logic             w_illegal_op;

    always_comb begin
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_addr_sel   = 1'b0;
        w_load_acc   = 1'b0;
        w_acc_src    = ACCSRC_ALU;
        w_inc_pc     = 1'b0;
        w_load_pc    = 1'b0;
        w_halted     = 1'b0;
        w_bus_err    = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_inc_pc   = memReady;
            end
            S_DECODE: begin
                w_illegal_op = w_illegal;
                case (w_opcode)
                    OP_W'(OP_LDI): begin
                        w_load_acc = 1'b1;
                        w_acc_src  = ACCSRC_IMM;
                    end
                    OP_W'(OP_JMP): w_load_pc = 1'b1;
                    OP_W'(OP_JZ):  w_load_pc = accZero;
                    default:       ;
                endcase
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_addr_sel = 1'b1;
                w_load_acc = memReady;
                w_acc_src  = w_is_alu ? ACCSRC_ALU : ACCSRC_MEM;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_addr_sel  = 1'b1;
            end
            S_HALT: w_halted = 1'b1;
            S_ERROR: begin
                w_halted  = 1'b1;
                w_bus_err = 1'b1;
            end
            default: ;
        endcase
    end

    // The state register resets to FETCH, whose decode would request a read;
    // gating with reset keeps every output quiet while reset is held.
    assign memRead   = w_mem_read   & ~reset;
    assign memWrite  = w_mem_write  & ~reset;
    assign addrSel   = w_addr_sel   & ~reset;
    assign operand   = reset ? '0 : r_ir[OPND_W-1:0];
    assign loadAcc   = w_load_acc   & ~reset;
    assign accSrc    = reset ? ACCSRC_ALU : w_acc_src;
    assign aluOp     = reset ? 2'b00 : w_alu_op;
    assign incPC     = w_inc_pc     & ~reset;
    assign loadPC    = w_load_pc    & ~reset;
    assign halted    = w_halted     & ~reset;
    assign busErr    = w_bus_err    & ~reset;
    assign illegalOp = w_illegal_op & ~reset;

endmodule : acc_control_unit
`default_nettype wire

// File: tb/tb_acc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_control_unit
//  Purpose  : Self-checking bench for acc_control_unit. Each scenario queues
//             per-cycle stimulus with the expected output vector; expected
//             vectors move to a scoreboard queue as stimulus is applied and
//             are popped and compared once the outputs settle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       memReady = 1'b0;
    logic [7:0] memDataIn = 8'h00;
    logic       accZero = 1'b0;
    logic       memRead, memWrite, addrSel, loadAcc, incPC, loadPC;
    logic       halted, busErr, illegalOp;
    logic [3:0] operand;
    logic [1:0] accSrc, aluOp;

    acc_control_unit #(
        .OP_W       (4),
        .OPND_W     (4),
        .WAIT_LIMIT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memReady  (memReady),
        .memDataIn (memDataIn),
        .accZero   (accZero),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addrSel   (addrSel),
        .operand   (operand),
        .loadAcc   (loadAcc),
        .accSrc    (accSrc),
        .aluOp     (aluOp),
        .incPC     (incPC),
        .loadPC    (loadPC),
        .halted    (halted),
        .busErr    (busErr),
        .illegalOp (illegalOp)
    );

    always #5 clk = ~clk;

    // {rd, wr, addrSel, operand[3:0], loadAcc, accSrc[1:0], aluOp[1:0],
    //  incPC, loadPC, halted, busErr, illegalOp}
    logic [16:0] obs;
    assign obs = {memRead, memWrite, addrSel, operand, loadAcc, accSrc, aluOp,
                  incPC, loadPC, halted, busErr, illegalOp};

    localparam logic [16:0] M_ALL  = 17'h1FFFF;
    localparam logic [16:0] M_BASE = 17'h1FE1F;  // accSrc, aluOp ignored
    localparam logic [16:0] M_SRC  = 17'h1FF9F;  // aluOp ignored

    typedef struct {
        logic        rdy;
        logic        az;
        logic [7:0]  din;
        logic [16:0] ev;
        logic [16:0] em;
        string       tag;
    } stim_t;

    typedef struct {
        logic [16:0] ev;
        logic [16:0] em;
        string       tag;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic logic [16:0] ov(input logic rd, input logic wr, input logic as,
                                       input logic [3:0] op, input logic la,
                                       input logic [1:0] src, input logic [1:0] alu,
                                       input logic inc, input logic lpc, input logic hlt,
                                       input logic be, input logic ill);
        return {rd, wr, as, op, la, src, alu, inc, lpc, hlt, be, ill};
    endfunction

    task automatic add(input logic rdy, input logic az, input logic [7:0] din,
                       input logic [16:0] ev, input logic [16:0] em, input string tag);
        stim_t s;
        s.rdy = rdy; s.az = az; s.din = din; s.ev = ev; s.em = em; s.tag = tag;
        sq.push_back(s);
    endtask

    // Ends on a falling edge with reset released and the FSM in FETCH.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        memReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        do_reset();
        add(0, 0, 8'h00, ov(1,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "rst_first_fetch");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
        // Still waiting in FETCH with memRead high; assert reset mid-cycle.
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (obs !== 17'h0) begin
            miscompares++;
            $display("FAIL rst_async: got %h want %h", obs, 17'h0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== 17'h0) begin
            miscompares++;
            $display("FAIL rst_hold: got %h want %h", obs, 17'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        add(0, 0, 8'h00, ov(1,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "rst_release");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    // LDI 5; ADD [3]; STA [4] with zero-wait memory.
    task automatic test_program();
        stim_t s;
        exp_t  e;
        do_reset();
        add(1, 0, 8'h85, ov(1,0,0,4'h0,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "prog_c1_fetch");
        add(0, 0, 8'h00, ov(0,0,0,4'h5,1,2'b10,2'b00,0,0,0,0,0), M_SRC,  "prog_c2_ldi");
        add(1, 0, 8'h33, ov(1,0,0,4'h5,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "prog_c3_fetch");
        add(0, 0, 8'h00, ov(0,0,0,4'h3,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "prog_c4_decode");
        add(1, 0, 8'h07, ov(1,0,1,4'h3,1,2'b00,2'b00,0,0,0,0,0), M_ALL,  "prog_c5_add");
        add(1, 0, 8'h24, ov(1,0,0,4'h3,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "prog_c6_fetch");
        add(0, 0, 8'h00, ov(0,0,0,4'h4,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "prog_c7_decode");
        add(1, 0, 8'h00, ov(0,1,1,4'h4,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "prog_c8_sta");
        add(0, 0, 8'h00, ov(1,0,0,4'h4,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "prog_c9_fetch");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jz();
        stim_t s;
        exp_t  e;
        do_reset();
        add(1, 1, 8'h7A, ov(1,0,0,4'h0,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "jz_fetch1");
        add(0, 1, 8'h00, ov(0,0,0,4'hA,0,2'b00,2'b00,0,1,0,0,0), M_BASE, "jz_taken");
        add(1, 0, 8'h7A, ov(1,0,0,4'hA,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "jz_fetch2");
        add(0, 0, 8'h00, ov(0,0,0,4'hA,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "jz_not_taken");
        add(1, 0, 8'h6C, ov(1,0,0,4'hA,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "jmp_fetch");
        add(0, 0, 8'h00, ov(0,0,0,4'hC,0,2'b00,2'b00,0,1,0,0,0), M_BASE, "jmp_decode");
        add(0, 0, 8'h00, ov(1,0,0,4'hC,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "jmp_next_fetch");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    // LDA [2] with memReady held off for 3 cycles of MEM_RD.
    task automatic test_lda_wait();
        stim_t s;
        exp_t  e;
        do_reset();
        add(1, 0, 8'h12, ov(1,0,0,4'h0,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "lda_fetch");
        add(0, 0, 8'h00, ov(0,0,0,4'h2,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "lda_decode");
        for (int i = 0; i < 3; i++)
            add(0, 0, 8'h00, ov(1,0,1,4'h2,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "lda_wait");
        add(1, 0, 8'h5A, ov(1,0,1,4'h2,1,2'b01,2'b00,0,0,0,0,0), M_SRC,  "lda_load");
        add(0, 0, 8'h00, ov(1,0,0,4'h2,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "lda_next_fetch");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    // memReady withheld for 15 cycles in FETCH, then ERROR is sticky.
    task automatic test_timeout();
        stim_t s;
        exp_t  e;
        do_reset();
        for (int i = 0; i < 15; i++)
            add(0, 0, 8'h00, ov(1,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "to_waiting");
        for (int i = 0; i < 4; i++)
            add(i[0], 0, 8'h85, ov(0,0,0,4'h0,0,2'b00,2'b00,0,0,1,1,0), M_BASE, "to_error");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    // Ready on the 15th cycle completes; repeated to show the counter restarts.
    task automatic test_limit_ready();
        stim_t s;
        exp_t  e;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 14; i++)
                add(0, 0, 8'h00, ov(1,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "lim_waiting");
            add(1, 0, 8'h00, ov(1,0,0,4'h0,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "lim_ready");
            add(0, 0, 8'h00, ov(0,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "lim_nop_decode");
        end
        add(0, 0, 8'h00, ov(1,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "lim_next_fetch");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_halt();
        stim_t s;
        exp_t  e;
        do_reset();
        add(1, 0, 8'hB7, ov(1,0,0,4'h0,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "ill_fetch");
        add(1, 0, 8'h00, ov(0,0,0,4'h7,0,2'b00,2'b00,0,0,0,0,1), M_BASE, "ill_pulse");
        add(1, 0, 8'hF0, ov(1,0,0,4'h7,0,2'b00,2'b00,1,0,0,0,0), M_BASE, "hlt_fetch");
        add(1, 1, 8'h00, ov(0,0,0,4'h0,0,2'b00,2'b00,0,0,0,0,0), M_BASE, "hlt_decode");
        for (int i = 0; i < 22; i++)
            add(i[0], i[1], 8'h61, ov(0,0,0,4'h0,0,2'b00,2'b00,0,0,1,0,0), M_BASE, "hlt_parked");
        while (sq.size() > 0) begin
            s = sq.pop_front();
            memReady = s.rdy; accZero = s.az; memDataIn = s.din;
            e.ev = s.ev; e.em = s.em; e.tag = s.tag; eq.push_back(e);
            #1;
            e = eq.pop_front();
            vectors++;
            if ((obs & e.em) !== (e.ev & e.em)) begin
                miscompares++;
                $display("FAIL %s: got %h want %h (mask %h)", e.tag, obs, e.ev, e.em);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2;
        vectors++;
        if (obs !== 17'h0) begin
            miscompares++;
            $display("FAIL power_on_reset: got %h want %h", obs, 17'h0);
        end
        test_reset();
        test_program();
        test_jz();
        test_lda_wait();
        test_timeout();
        test_limit_ready();
        test_illegal_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_acc_control_unit
`default_nettype wire
